// File: rtl/wb_load_return.sv
// In-order load/store return tracker with writeback data extraction and sign/zero extension.
// Optional same-cycle response-to-writeback bypass is enabled by defining WB_LOAD_RETURN_BYPASS_EN.
module wb_load_return #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_is_load,
    input  logic [2:0]                req_funct3,
    input  logic [$clog2(XLEN/8)-1:0] req_offset,
    input  logic [4:0]                req_rd_addr,
    input  logic                      dmem_resp,
    input  logic [XLEN-1:0]           dmem_rdata,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic                      wb_is_load,
    output logic [4:0]                wb_rd_addr,
    output logic [XLEN-1:0]           wb_data,
    output logic [XLEN-1:0]           wb_raw,
    output logic [$clog2(DEPTH):0]    outstanding,
    output logic                      err_unexp_resp
);

    localparam int OW = $clog2(XLEN/8);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic            r_is_load [DEPTH];
    logic [2:0]      r_funct3  [DEPTH];
    logic [OW-1:0]   r_offset  [DEPTH];
    logic [4:0]      r_rd      [DEPTH];
    logic [XLEN-1:0] r_data    [DEPTH];
    logic            r_done    [DEPTH];

    logic [PW-1:0]   r_tail;
    logic [PW-1:0]   r_rptr;
    logic [PW-1:0]   r_head;
    logic [PW:0]     r_count;
    logic [PW:0]     r_pend;
    logic            r_err;

    logic            w_alloc;
    logic            w_resp;
    logic            w_retire;
    logic            w_bypass;
    logic            w_pend_nz;
    logic [XLEN-1:0] w_raw;

    // Misaligned low offset bits are masked so halfword/word lanes align down.
    function automatic logic [XLEN-1:0] f_extend(
        input logic [XLEN-1:0] data,
        input logic [2:0]      f3,
        input logic [OW-1:0]   off,
        input logic            is_load
    );
        logic [OW-1:0]   v_off_h;
        logic [OW-1:0]   v_off_w;
        logic [XLEN-1:0] v_b;
        logic [XLEN-1:0] v_h;
        logic [XLEN-1:0] v_w;
        logic [XLEN-1:0] v_res;
        v_off_h = off & ~OW'(1);
        v_off_w = off & ~OW'(3);
        v_b     = data >> {off, 3'b000};
        v_h     = data >> {v_off_h, 3'b000};
        v_w     = data >> {v_off_w, 3'b000};
        v_res   = '0;
        case (f3)
            3'b000:  v_res = XLEN'($signed(v_b[7:0]));
            3'b001:  v_res = XLEN'($signed(v_h[15:0]));
            3'b010:  v_res = XLEN'($signed(v_w[31:0]));
            3'b011:  v_res = (XLEN == 64) ? data : '0;
            3'b100:  v_res = XLEN'(v_b[7:0]);
            3'b101:  v_res = XLEN'(v_h[15:0]);
            3'b110:  v_res = (XLEN == 64) ? XLEN'(v_w[31:0]) : '0;
            default: v_res = '0;
        endcase
        return is_load ? v_res : '0;
    endfunction

    assign req_ready  = (r_count != FULL);
    assign w_pend_nz  = (r_pend != '0);
    assign w_alloc    = req_valid && req_ready;
    assign w_resp     = dmem_resp && w_pend_nz;
    assign w_retire   = wb_valid && wb_ready;

`ifdef WB_LOAD_RETURN_BYPASS_EN
    assign w_bypass   = w_resp && (r_head == r_rptr) && !r_done[r_head];
    assign w_raw      = w_bypass ? dmem_rdata : r_data[r_head];
    assign wb_valid   = r_done[r_head] || w_bypass;
`else
    assign w_bypass   = 1'b0;
    assign w_raw      = r_data[r_head];
    assign wb_valid   = r_done[r_head];
`endif

    assign wb_is_load     = r_is_load[r_head];
    assign wb_rd_addr     = r_rd[r_head];
    assign wb_raw         = w_raw;
    assign wb_data        = f_extend(w_raw, r_funct3[r_head], r_offset[r_head], r_is_load[r_head]);
    assign outstanding    = r_count;
    assign err_unexp_resp = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_is_load[i] <= 1'b0;
                r_funct3[i]  <= '0;
                r_offset[i]  <= '0;
                r_rd[i]      <= '0;
                r_data[i]    <= '0;
                r_done[i]    <= 1'b0;
            end
            r_tail  <= '0;
            r_rptr  <= '0;
            r_head  <= '0;
            r_count <= '0;
            r_pend  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_is_load[r_tail] <= req_is_load;
                r_funct3[r_tail]  <= req_funct3;
                r_offset[r_tail]  <= req_offset;
                r_rd[r_tail]      <= req_rd_addr;
                r_done[r_tail]    <= 1'b0;
                r_tail            <= r_tail + PW'(1);
            end
            if (w_retire) begin
                r_done[r_head] <= 1'b0;
                r_head         <= r_head + PW'(1);
            end
            // A bypassed entry retiring this cycle must not be left marked done.
            if (w_resp) begin
                r_data[r_rptr] <= dmem_rdata;
                if (!(w_bypass && w_retire)) begin
                    r_done[r_rptr] <= 1'b1;
                end
                r_rptr <= r_rptr + PW'(1);
            end
            if (dmem_resp && !w_pend_nz) begin
                r_err <= 1'b1;
            end
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
            case ({w_alloc, w_resp})
                2'b10:   r_pend <= r_pend + (PW+1)'(1);
                2'b01:   r_pend <= r_pend - (PW+1)'(1);
                default: r_pend <= r_pend;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_load_return.sv
// Scoreboard bench for wb_load_return (XLEN=32, DEPTH=4): expected writeback entries are
// queued at issue time and compared when the head entry presents valid data.
module tb_wb_load_return;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_load;
    logic [2:0]  req_funct3;
    logic [1:0]  req_offset;
    logic [4:0]  req_rd_addr;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_is_load;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_raw;
    logic [2:0]  outstanding;
    logic        err_unexp_resp;

    typedef struct {
        logic        is_load;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] raw;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] resp_q[$];
    int          n_checks;
    int          n_fail;

    wb_load_return #(.XLEN(32), .DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_load    (req_is_load),
        .req_funct3     (req_funct3),
        .req_offset     (req_offset),
        .req_rd_addr    (req_rd_addr),
        .dmem_resp      (dmem_resp),
        .dmem_rdata     (dmem_rdata),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_is_load     (wb_is_load),
        .wb_rd_addr     (wb_rd_addr),
        .wb_data        (wb_data),
        .wb_raw         (wb_raw),
        .outstanding    (outstanding),
        .err_unexp_resp (err_unexp_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_ext(input logic [31:0] d, input logic [2:0] f3,
                                              input logic [1:0] off);
        logic [31:0] bb;
        logic [31:0] hh;
        bb = (d >> (8 * off)) & 32'h0000_00FF;
        hh = (d >> (16 * (off / 2))) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return bb[7] ? (bb | 32'hFFFF_FF00) : bb;
            3'd1:    return hh[15] ? (hh | 32'hFFFF_0000) : hh;
            3'd2:    return d;
            3'd4:    return bb;
            3'd5:    return hh;
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle_inputs();
        req_valid   = 1'b0;
        req_is_load = 1'b0;
        req_funct3  = 3'd0;
        req_offset  = 2'd0;
        req_rd_addr = 5'd0;
        dmem_resp   = 1'b0;
        dmem_rdata  = 32'h0;
    endtask

    // Drives one random request and queues its response data and expected writeback.
    task automatic gen_item();
        exp_t e;
        logic [31:0] d;
        d           = $urandom;
        req_valid   = 1'b1;
        req_is_load = ($urandom_range(0, 3) != 0);
        req_funct3  = 3'($urandom_range(0, 7));
        req_offset  = 2'($urandom_range(0, 3));
        req_rd_addr = 5'($urandom_range(0, 31));
        e.is_load   = req_is_load;
        e.rd        = req_rd_addr;
        e.raw       = d;
        e.data      = req_is_load ? model_ext(d, req_funct3, req_offset) : 32'h0;
        sb.push_back(e);
        resp_q.push_back(d);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        wb_ready = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        n_checks += 8;
        if (req_ready !== 1'b1)      begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        if (wb_valid !== 1'b0)       begin n_fail++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
        if (wb_is_load !== 1'b0)     begin n_fail++; $display("FAIL reset_wb_is_load got %b exp 0", wb_is_load); end
        if (wb_rd_addr !== 5'd0)     begin n_fail++; $display("FAIL reset_wb_rd_addr got %0d exp 0", wb_rd_addr); end
        if (wb_data !== 32'h0)       begin n_fail++; $display("FAIL reset_wb_data got %h exp 0", wb_data); end
        if (wb_raw !== 32'h0)        begin n_fail++; $display("FAIL reset_wb_raw got %h exp 0", wb_raw); end
        if (outstanding !== 3'd0)    begin n_fail++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
        if (err_unexp_resp !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err_unexp_resp); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_lb();
        exp_t e;
        logic exp_v_n;
        @(negedge clk);
        req_valid = 1'b1; req_is_load = 1'b1; req_funct3 = 3'b000;
        req_offset = 2'd2; req_rd_addr = 5'd5;
        e.is_load = 1'b1; e.rd = 5'd5; e.data = 32'hFFFF_FF80; e.raw = 32'h1180_7F22;
        sb.push_back(e);
        @(negedge clk);
        idle_inputs();
        dmem_resp = 1'b1; dmem_rdata = 32'h1180_7F22;
        #1;
`ifdef WB_LOAD_RETURN_BYPASS_EN
        exp_v_n = 1'b1;
`else
        exp_v_n = 1'b0;
`endif
        n_checks += 2;
        if (wb_valid !== exp_v_n)  begin n_fail++; $display("FAIL lb_valid_at_N got %b exp %b", wb_valid, exp_v_n); end
        if (outstanding !== 3'd1)  begin n_fail++; $display("FAIL lb_outstanding got %0d exp 1", outstanding); end
        @(negedge clk);
        dmem_resp = 1'b0; wb_ready = 1'b1;
        #1;
        n_checks++;
        if (wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL lb_valid_at_N1 got %b exp 1", wb_valid);
        end else begin
            e = sb.pop_front();
            n_checks += 4;
            if (wb_rd_addr !== e.rd)      begin n_fail++; $display("FAIL lb_rd got %0d exp %0d", wb_rd_addr, e.rd); end
            if (wb_data !== e.data)       begin n_fail++; $display("FAIL lb_data got %h exp %h", wb_data, e.data); end
            if (wb_raw !== e.raw)         begin n_fail++; $display("FAIL lb_raw got %h exp %h", wb_raw, e.raw); end
            if (wb_is_load !== e.is_load) begin n_fail++; $display("FAIL lb_is_load got %b exp %b", wb_is_load, e.is_load); end
        end
        @(negedge clk);
        wb_ready = 1'b0;
        #1;
        n_checks += 2;
        if (wb_valid !== 1'b0)    begin n_fail++; $display("FAIL lb_after_retire_valid got %b exp 0", wb_valid); end
        if (outstanding !== 3'd0) begin n_fail++; $display("FAIL lb_after_retire_outstanding got %0d exp 0", outstanding); end
    endtask

    task automatic test_ext_matrix();
        logic [2:0]  f3s  [7] = '{3'b100, 3'b001, 3'b101, 3'b010, 3'b011, 3'b000, 3'b001};
        logic [1:0]  offs [7] = '{2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd3};
        logic [31:0] exps [7] = '{32'h0000_00FF, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_F0FF,
                                  32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_8001};
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_is_load = 1'b1; req_funct3 = f3s[i];
            req_offset = offs[i]; req_rd_addr = 5'(i + 1);
            e.is_load = 1'b1; e.rd = 5'(i + 1); e.data = exps[i]; e.raw = 32'h8001_F0FF;
            sb.push_back(e);
            @(negedge clk);
            idle_inputs();
            dmem_resp = 1'b1; dmem_rdata = 32'h8001_F0FF;
            @(negedge clk);
            dmem_resp = 1'b0; wb_ready = 1'b1;
            #1;
            n_checks++;
            if (wb_valid !== 1'b1) begin
                n_fail++; $display("FAIL ext_valid[%0d] got %b exp 1", i, wb_valid);
            end else begin
                e = sb.pop_front();
                n_checks += 2;
                if (wb_data !== e.data) begin n_fail++; $display("FAIL ext_data[%0d] got %h exp %h", i, wb_data, e.data); end
                if (wb_rd_addr !== e.rd) begin n_fail++; $display("FAIL ext_rd[%0d] got %0d exp %0d", i, wb_rd_addr, e.rd); end
            end
            @(negedge clk);
            wb_ready = 1'b0;
        end
    endtask

    task automatic test_full_stall();
        exp_t e;
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_is_load = 1'b1; req_funct3 = 3'b010;
            req_offset = 2'd0; req_rd_addr = 5'(10 + i);
            e.is_load = 1'b1; e.rd = 5'(10 + i);
            e.raw = 32'hA000_0000 + 32'(i); e.data = e.raw;
            sb.push_back(e);
        end
        // Extra request while full must be dropped.
        @(negedge clk);
        req_rd_addr = 5'd31;
        #1;
        n_checks += 2;
        if (req_ready !== 1'b0)   begin n_fail++; $display("FAIL full_req_ready got %b exp 0", req_ready); end
        if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_outstanding got %0d exp 4", outstanding); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            dmem_resp = 1'b1; dmem_rdata = 32'hA000_0000 + 32'(i);
        end
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        n_checks += 2;
        if (outstanding !== 3'd4) begin n_fail++; $display("FAIL stall_outstanding got %0d exp 4", outstanding); end
        if (wb_valid !== 1'b1)    begin n_fail++; $display("FAIL stall_valid got %b exp 1", wb_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wb_ready = 1'b1;
            #1;
            n_checks += 2;
            if (req_ready !== (i != 0)) begin n_fail++; $display("FAIL drain_req_ready[%0d] got %b exp %b", i, req_ready, (i != 0)); end
            if (wb_valid !== 1'b1) begin
                n_fail++; $display("FAIL drain_valid[%0d] got %b exp 1", i, wb_valid);
            end else begin
                e = sb.pop_front();
                n_checks += 2;
                if (wb_rd_addr !== e.rd) begin n_fail++; $display("FAIL drain_rd[%0d] got %0d exp %0d", i, wb_rd_addr, e.rd); end
                if (wb_data !== e.data)  begin n_fail++; $display("FAIL drain_data[%0d] got %h exp %h", i, wb_data, e.data); end
            end
        end
        @(negedge clk);
        wb_ready = 1'b0;
        #1;
        n_checks += 2;
        if (wb_valid !== 1'b0)    begin n_fail++; $display("FAIL drained_valid got %b exp 0", wb_valid); end
        if (outstanding !== 3'd0) begin n_fail++; $display("FAIL drained_outstanding got %0d exp 0", outstanding); end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        @(negedge clk);
        gen_item();
        @(negedge clk);
        gen_item();
        dmem_resp = 1'b1; dmem_rdata = resp_q.pop_front();
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (j < 10) gen_item();
            else req_valid = 1'b0;
            dmem_resp = (resp_q.size() != 0);
            dmem_rdata = (resp_q.size() != 0) ? resp_q.pop_front() : 32'h0;
            wb_ready = 1'b1;
            #1;
            if (j < 10) begin
                n_checks++;
                if (outstanding !== 3'd2) begin n_fail++; $display("FAIL simul_outstanding[%0d] got %0d exp 2", j, outstanding); end
            end
            if (sb.size() != 0) begin
                n_checks++;
                if (wb_valid !== 1'b1) begin
                    n_fail++; $display("FAIL simul_valid[%0d] got %b exp 1", j, wb_valid);
                end else begin
                    e = sb.pop_front();
                    n_checks += 4;
                    if (wb_is_load !== e.is_load) begin n_fail++; $display("FAIL simul_is_load[%0d] got %b exp %b", j, wb_is_load, e.is_load); end
                    if (wb_rd_addr !== e.rd)      begin n_fail++; $display("FAIL simul_rd[%0d] got %0d exp %0d", j, wb_rd_addr, e.rd); end
                    if (wb_data !== e.data)       begin n_fail++; $display("FAIL simul_data[%0d] got %h exp %h", j, wb_data, e.data); end
                    if (wb_raw !== e.raw)         begin n_fail++; $display("FAIL simul_raw[%0d] got %h exp %h", j, wb_raw, e.raw); end
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        wb_ready = 1'b0;
        #1;
        n_checks += 2;
        if (outstanding !== 3'd0) begin n_fail++; $display("FAIL simul_end_outstanding got %0d exp 0", outstanding); end
        if (sb.size() != 0)       begin n_fail++; $display("FAIL simul_leftover got %0d exp 0", sb.size()); end
    endtask

    task automatic test_bypass();
`ifdef WB_LOAD_RETURN_BYPASS_EN
        @(negedge clk);
        req_valid = 1'b1; req_is_load = 1'b1; req_funct3 = 3'b010;
        req_offset = 2'd0; req_rd_addr = 5'd7;
        @(negedge clk);
        idle_inputs();
        dmem_resp = 1'b1; dmem_rdata = 32'h0000_0042; wb_ready = 1'b1;
        #1;
        n_checks += 3;
        if (wb_valid !== 1'b1)       begin n_fail++; $display("FAIL bypass_valid got %b exp 1", wb_valid); end
        if (wb_data !== 32'h42)      begin n_fail++; $display("FAIL bypass_data got %h exp 42", wb_data); end
        if (wb_rd_addr !== 5'd7)     begin n_fail++; $display("FAIL bypass_rd got %0d exp 7", wb_rd_addr); end
        @(negedge clk);
        dmem_resp = 1'b0; wb_ready = 1'b0;
        #1;
        n_checks += 2;
        if (outstanding !== 3'd0)    begin n_fail++; $display("FAIL bypass_outstanding got %0d exp 0", outstanding); end
        if (wb_valid !== 1'b0)       begin n_fail++; $display("FAIL bypass_after_valid got %b exp 0", wb_valid); end
`endif
    endtask

    task automatic test_unexpected();
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++;
        if (err_unexp_resp !== 1'b0) begin n_fail++; $display("FAIL unexp_pre got %b exp 0", err_unexp_resp); end
        dmem_resp = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_resp = 1'b0;
        #1;
        n_checks += 3;
        if (err_unexp_resp !== 1'b1) begin n_fail++; $display("FAIL unexp_set got %b exp 1", err_unexp_resp); end
        if (outstanding !== 3'd0)    begin n_fail++; $display("FAIL unexp_outstanding got %0d exp 0", outstanding); end
        if (wb_valid !== 1'b0)       begin n_fail++; $display("FAIL unexp_valid got %b exp 0", wb_valid); end
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (err_unexp_resp !== 1'b1) begin n_fail++; $display("FAIL unexp_sticky got %b exp 1", err_unexp_resp); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1; req_is_load = 1'b1; req_funct3 = 3'b010; req_rd_addr = 5'd9;
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++;
        if (outstanding !== 3'd1) begin n_fail++; $display("FAIL mid_pre_outstanding got %0d exp 1", outstanding); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (outstanding !== 3'd0)    begin n_fail++; $display("FAIL mid_async_outstanding got %0d exp 0", outstanding); end
        if (err_unexp_resp !== 1'b0) begin n_fail++; $display("FAIL mid_async_err got %b exp 0", err_unexp_resp); end
        if (req_ready !== 1'b1)      begin n_fail++; $display("FAIL mid_async_req_ready got %b exp 1", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_lb();
        test_ext_matrix();
        test_full_stall();
        test_simultaneous();
        test_bypass();
        test_unexpected();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_load_return.md
# wb_load_return

Parametrised load/store return tracker and writeback data formatter for the data-memory path. Sits between the memory stage and the register-file write port. It records up to DEPTH outstanding data-memory accesses in program order and captures in-order `dmem` responses, including responses that arrive while writeback is stalled. It retires each access to writeback with correctly extracted and sign- or zero-extended load data, which removes the single-response probe limitation of the current writeback stage.

## Interface
- `XLEN`, default 32, sets the data width; legal values are 32 and 64.
- `DEPTH`, default 4, sets the number of outstanding accesses; must be a power of 2 in the range 2..16.
- `clk  in  1` is the single clock; all state changes on its rising edge.
- `rst_n  in  1` is the reset: asynchronous, active-low.
- `req_valid  in  1` indicates the memory stage is issuing a data-memory access this cycle.
- `req_ready  out  1` indicates the tracker can accept an access; it equals `count != DEPTH`.
- `req_is_load  in  1` is 1 for a load and 0 for a store.
- `req_funct3  in  3` is the load funct3.
- `req_offset  in  $clog2(XLEN/8)` is the byte offset within the word (the low address bits).
- `req_rd_addr  in  5` is the destination register.
- `dmem_resp  in  1` is the memory response strobe. Responses arrive in request order, one per access, for both loads and stores.
- `dmem_rdata  in  XLEN` is the response data.
- `wb_valid  out  1` indicates the head entry is complete.
- `wb_ready  in  1` is the writeback-advance signal, driven by `wb_reg_we`.
- `wb_is_load  out  1` is the head entry's load flag.
- `wb_rd_addr  out  5` is the head entry's destination register.
- `wb_data  out  XLEN` is the extended load result.
- `wb_raw  out  XLEN` is the unmodified memory word, used for RVFI `mem_rdata`.
- `outstanding  out  $clog2(DEPTH)+1` is the live entry count.
- `err_unexp_resp  out  1` is a sticky flag set when `dmem_resp` arrives with no pending entry.

## Operation
- **Storage:** a circular buffer of DEPTH entries. Each entry holds `{is_load, funct3, offset, rd, data, done}`.
- **Pointers:** three pointers of width `$clog2(DEPTH)`, each wrapping modulo DEPTH:
  - `tail` is the allocation pointer.
  - `rptr` is the next entry awaiting a response.
  - `head` is the retire pointer.
- **Allocate:** when `req_valid && req_ready`, write the entry at `tail` with `done=0`, then increment `tail`.
- **Accept vs. drop:** `req_valid` while `req_ready`=0 is ignored; the upstream stage must hold the request.
- **Respond:** when `dmem_resp` and `pend != 0`, where `pend = (tail - rptr)` including the wrap/full case:
  - write `data` at `rptr` and set `done=1`;
  - increment `rptr`.
- **Unexpected response:** `dmem_resp` with `pend == 0` is dropped and sets `err_unexp_resp`. The flag is cleared only by reset.
- **Retire:** when `wb_valid && wb_ready`, clear `done` at `head` and increment `head`.
- **Count update:** `count` is incremented on allocate and decremented on retire. It is unchanged when both happen in the same cycle, and all three operations may occur in one cycle.
- **Full-buffer retire:** `req_ready` is not bypassed by a same-cycle retire. A full buffer accepts a new request no earlier than the cycle after a retire.
- **Head-entry outputs:** `wb_is_load`, `wb_rd_addr` and `wb_raw` come from the head entry.
- **Lane selection:** the byte lane is `8*offset`. Halfword accesses use `offset[msb:1]` and word accesses use `offset[msb:2]`. Misaligned low bits are ignored, so the address aligns down.
- **Extension by funct3:**
  - 000 lb: sign-extend byte.
  - 001 lh: sign-extend half.
  - 010 lw: word, sign-extended when XLEN=64.
  - 011 ld: full XLEN, valid only when XLEN=64.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half.
  - 110 lwu: zero-extend word, valid only when XLEN=64.
  - Any other code, including 011/110 when XLEN=32, gives `wb_data` = 0. Never X.
- **Stores:** a store entry produces `wb_data` = 0; the consumer ignores it via `wb_is_load`.

## Timing
- **Reset values:** `req_ready`=1, `wb_valid`=0, `wb_is_load`=0, `wb_rd_addr`=0, `wb_data`=0, `wb_raw`=0, `outstanding`=0, `err_unexp_resp`=0. All pointers and entry fields are cleared.
- **Reset mid-operation:** asserting `rst_n` low discards all entries immediately (asynchronously). Responses to accesses issued before reset then raise `err_unexp_resp` after reset releases; the system must drain memory before releasing reset.
- **Latency without bypass:** response at cycle N gives `wb_valid`=1 at N+1.
- **Retire latency:** retire is a single cycle per entry; back-to-back retires proceed while head entries are `done`.
- **Stall:** if `wb_ready`=0, the head entry holds and its outputs stay stable. Later responses continue to fill entries until `pend` = 0.
- **Outputs:** `wb_*` and `outstanding` depend only on registered state, except under the bypass below.

## Configuration
- Macro: `WB_LOAD_RETURN_BYPASS_EN`.
- **When defined:** if `head == rptr`, head is not `done`, and `dmem_resp`=1, then in the same cycle:
  - `wb_valid`=1;
  - `wb_raw` = `dmem_rdata`, and `wb_data` is extended from `dmem_rdata`.
  
  If `wb_ready` is also 1, the entry retires that cycle without ever setting `done`, giving zero-cycle response-to-writeback latency. This adds a combinational path from `dmem_resp`/`dmem_rdata` to `wb_*`.
- **When undefined:** there is no bypass; all `wb_*` outputs are registered-state driven with 1-cycle latency.

## Test plan
- **Reset, then a single lb:** reset, then issue lb with `offset`=2, `rd`=5, respond `dmem_rdata`=0x1180_7F22. Required: `wb_valid` at N+1, `wb_rd_addr`=5, `wb_data`=0xFFFF_FF80, `wb_raw`=0x1180_7F22.
- **Extension matrix, XLEN=32:** respond 0x8001_F0FF. Required results:
  - lbu with `offset`=0: 0x0000_00FF.
  - lh with `offset`=2: 0xFFFF_8001.
  - lhu with `offset`=2: 0x0000_8001.
  - lw: 0x8001_F0FF.
  - funct3=011: 0.
- **Full and stalled:** with DEPTH=4 and `wb_ready`=0:
  - issue 4 loads; `req_ready`=0 and `outstanding`=4;
  - deliver 4 responses; all 4 entries become `done`;
  - raise `wb_ready`; 4 retires occur on consecutive cycles in order;
  - `req_ready`=1 the cycle after the first retire.
- **Simultaneous events:** in one cycle, allocate, respond and retire. Required: `outstanding` unchanged, pointers each advance by 1, and the wrap from index 3 to 0 is correct.
- **Unexpected response:** `dmem_resp` with nothing pending. Required: `err_unexp_resp`=1 the next cycle and it stays set; `outstanding` stays 0.
- **Bypass, macro defined:** issue 1 load; respond 0x0000_0042 with `wb_ready`=1. Required: `wb_valid`=1 and `wb_data`=0x42 in the same cycle, and `outstanding`=0 the next cycle.
